// File: rtl/draw_list_scheduler_pkg.sv
// Shared constants, FSM encodings and the default-width draw-entry layout
// for the draw list scheduler.
package draw_list_scheduler_pkg;

  localparam logic [7:0] COMMAND_DRAW_SPRITE = 8'h21;
  localparam int         SPRITE_NUM          = 16;
  localparam int         SPRITE_W            = $clog2(SPRITE_NUM);
  localparam int         DRAW_LIST_DEPTH_DEF = 64;
  localparam int         COORD_W_DEF         = 10;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;

  typedef struct packed {
    logic [SPRITE_W-1:0]    sprite;
    logic [COORD_W_DEF-1:0] x;
    logic [COORD_W_DEF-1:0] y;
    logic [7:0]             flags;
  } draw_entry_t;

endpackage

// File: rtl/draw_list_scheduler_if.sv
// Draw-entry stream from the scheduler (master) to the renderer (slave).
interface draw_list_scheduler_if
  import draw_list_scheduler_pkg::*;
#(
  parameter int SPR_W = SPRITE_W,
  parameter int CRD_W = COORD_W_DEF
);
  logic             out_valid;
  logic             out_ready;
  logic [SPR_W-1:0] out_sprite;
  logic [CRD_W-1:0] out_x;
  logic [CRD_W-1:0] out_y;
  logic [7:0]       out_flags;
  logic             out_last;

  modport master (
    output out_valid, out_sprite, out_x, out_y, out_flags, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_sprite, out_x, out_y, out_flags, out_last,
    output out_ready
  );
endinterface

// File: rtl/draw_list_ram.sv
// Two-bank simple dual-port RAM: one write port, one registered read port,
// each with its own bank select. Array contents are never reset.
module draw_list_ram #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic                     wr_bank,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  input  logic                     rd_bank,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data
);
  logic [DATA_W-1:0] mem_r [2*DEPTH];

  // Write port
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_r[{wr_bank, wr_addr}] <= wr_data;
    end
  end

  // Read port; the data register holds between reads
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data <= {DATA_W{1'b0}};
    end else if (rd_en) begin
      rd_data <= mem_r[{rd_bank, rd_addr}];
    end
  end
endmodule

// File: rtl/draw_list_scheduler.sv
// Double-buffered sprite draw list: assembles 6-byte records into the back
// list and replays the front list to the renderer once per frame.
module draw_list_scheduler
  import draw_list_scheduler_pkg::*;
#(
  parameter int DRAW_LIST_DEPTH = DRAW_LIST_DEPTH_DEF,
  parameter int COORD_W         = COORD_W_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  draw_start,
  input  logic                  draw_byte_valid,
  input  logic [7:0]            draw_byte,
  input  logic                  list_commit,
  input  logic                  frame_start,
  draw_list_scheduler_if.master out_if,
  output logic                  busy,
  output logic                  list_dropped,
  output logic [7:0]            overrun_count
);
  localparam int IDX_W  = $clog2(DRAW_LIST_DEPTH);
  localparam int CNT_W  = IDX_W + 1;
  localparam int DATA_W = SPRITE_W + 2 * COORD_W + 8;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DRAW_LIST_DEPTH);

  logic [2:0]          byte_cnt_r;
  logic                rec_active_r;
  logic [SPRITE_W-1:0] sprite_r;
  logic [7:0]          x_hi_r, x_lo_r, y_hi_r, y_lo_r;
  logic [CNT_W-1:0]    back_count_r, front_count_r;
  logic [CNT_W-1:0]    back_count_next_s, front_count_next_s;
  logic                pending_r, front_sel_r, list_dropped_r;
  logic                rec_done_s, wr_en_s, swap_s;
  logic [15:0]         x_full_s, y_full_s;
  logic [DATA_W-1:0]   wr_data_s, rd_data_s;
  logic                unused_s;

  logic [1:0]          state_r, state_n_s;
  logic [IDX_W-1:0]    idx_r, idx_n_s;
  logic                out_valid_r, valid_n_s, out_last_r, last_n_s;
  logic                busy_r;
  logic [7:0]          overrun_r;

  // Record completion, back-list growth and swap decision
  always_comb begin
    x_full_s   = {x_hi_r, x_lo_r};
    y_full_s   = {y_hi_r, y_lo_r};
    rec_done_s = rec_active_r && draw_byte_valid && !draw_start && (byte_cnt_r == 3'd5);
    wr_en_s    = rec_done_s && (back_count_r != FULL_COUNT);
    wr_data_s  = {sprite_r, x_full_s[COORD_W-1:0], y_full_s[COORD_W-1:0], draw_byte};
    // A commit in the swap cycle counts, as does a record finishing that cycle
    swap_s     = frame_start && (pending_r || list_commit);
    if (wr_en_s) begin
      back_count_next_s = back_count_r + CNT_W'(1);
    end else begin
      back_count_next_s = back_count_r;
    end
    if (swap_s) begin
      front_count_next_s = back_count_next_s;
    end else begin
      front_count_next_s = front_count_r;
    end
  end

  assign unused_s = ^{x_full_s[15:COORD_W], y_full_s[15:COORD_W]};

  // Payload byte capture
  always_ff @(posedge clock) begin
    if (reset) begin
      byte_cnt_r   <= 3'd0;
      rec_active_r <= 1'b0;
      sprite_r     <= {SPRITE_W{1'b0}};
      x_hi_r       <= 8'd0;
      x_lo_r       <= 8'd0;
      y_hi_r       <= 8'd0;
      y_lo_r       <= 8'd0;
    end else if (draw_start) begin
      byte_cnt_r   <= 3'd0;
      rec_active_r <= 1'b1;
    end else if (list_commit) begin
      byte_cnt_r   <= 3'd0;
      rec_active_r <= 1'b0;
    end else if (draw_byte_valid && rec_active_r) begin
      case (byte_cnt_r)
        3'd0:    sprite_r <= draw_byte[SPRITE_W-1:0];
        3'd1:    x_hi_r   <= draw_byte;
        3'd2:    x_lo_r   <= draw_byte;
        3'd3:    y_hi_r   <= draw_byte;
        3'd4:    y_lo_r   <= draw_byte;
        default: ;
      endcase
      rec_active_r <= (byte_cnt_r != 3'd5);
      byte_cnt_r   <= (byte_cnt_r == 3'd5) ? 3'd0 : byte_cnt_r + 3'd1;
    end
  end

  // List bookkeeping: counts, pending flag, bank select, drop flag
  always_ff @(posedge clock) begin
    if (reset) begin
      back_count_r   <= {CNT_W{1'b0}};
      front_count_r  <= {CNT_W{1'b0}};
      pending_r      <= 1'b0;
      front_sel_r    <= 1'b0;
      list_dropped_r <= 1'b0;
    end else begin
      back_count_r  <= swap_s ? {CNT_W{1'b0}} : back_count_next_s;
      front_count_r <= front_count_next_s;
      pending_r     <= swap_s ? 1'b0 : (pending_r || list_commit);
      front_sel_r   <= front_sel_r ^ swap_s;
      if (list_commit) begin
        list_dropped_r <= 1'b0;
      end else if (rec_done_s && !wr_en_s) begin
        list_dropped_r <= 1'b1;
      end
    end
  end

  // Issue FSM next state; frame_start always restarts from index 0
  always_comb begin
    state_n_s = state_r;
    idx_n_s   = idx_r;
    valid_n_s = out_valid_r;
    last_n_s  = out_last_r;
    if (frame_start) begin
      idx_n_s   = IDX_W'(0);
      valid_n_s = 1'b0;
      last_n_s  = 1'b0;
      if (front_count_next_s != {CNT_W{1'b0}}) begin
        state_n_s = ST_LOAD;
      end else begin
        state_n_s = ST_IDLE;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          valid_n_s = 1'b0;
          last_n_s  = 1'b0;
        end
        ST_LOAD: begin
          state_n_s = ST_ISSUE;
          valid_n_s = 1'b1;
          last_n_s  = ({1'b0, idx_r} == front_count_r - CNT_W'(1));
        end
        ST_ISSUE: begin
          if (out_if.out_ready) begin
            valid_n_s = 1'b0;
            last_n_s  = 1'b0;
            if (out_last_r) begin
              state_n_s = ST_IDLE;
              idx_n_s   = IDX_W'(0);
            end else begin
              state_n_s = ST_LOAD;
              idx_n_s   = idx_r + IDX_W'(1);
            end
          end else begin
            state_n_s = ST_ISSUE;
          end
        end
        default: begin
          state_n_s = ST_IDLE;
          idx_n_s   = IDX_W'(0);
          valid_n_s = 1'b0;
          last_n_s  = 1'b0;
        end
      endcase
    end
  end

  // Issue FSM registers and status outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      idx_r       <= IDX_W'(0);
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      busy_r      <= 1'b0;
      overrun_r   <= 8'd0;
    end else begin
      state_r     <= state_n_s;
      idx_r       <= idx_n_s;
      out_valid_r <= valid_n_s;
      out_last_r  <= last_n_s;
      busy_r      <= (state_n_s != ST_IDLE);
      if (frame_start && (state_r != ST_IDLE) && (overrun_r != 8'hFF)) begin
        overrun_r <= overrun_r + 8'd1;
      end
    end
  end

  draw_list_ram #(
    .DEPTH  (DRAW_LIST_DEPTH),
    .DATA_W (DATA_W)
  ) u_ram (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en_s),
    .wr_bank (!front_sel_r),
    .wr_addr (back_count_r[IDX_W-1:0]),
    .wr_data (wr_data_s),
    .rd_en   (state_r == ST_LOAD),
    .rd_bank (front_sel_r),
    .rd_addr (idx_r),
    .rd_data (rd_data_s)
  );

  assign out_if.out_valid  = out_valid_r;
  assign out_if.out_last   = out_last_r;
  assign out_if.out_sprite = rd_data_s[DATA_W-1 -: SPRITE_W];
  assign out_if.out_x      = rd_data_s[2*COORD_W+7 -: COORD_W];
  assign out_if.out_y      = rd_data_s[COORD_W+7 -: COORD_W];
  assign out_if.out_flags  = rd_data_s[7:0];
  assign busy              = busy_r;
  assign list_dropped      = list_dropped_r;
  assign overrun_count     = overrun_r;
endmodule

// File: tb/tb_draw_list_scheduler.sv
// Directed bench for draw_list_scheduler with hand-computed expected entries.
module tb_draw_list_scheduler;
  logic       clock = 1'b0;
  logic       reset;
  logic       draw_start;
  logic       draw_byte_valid;
  logic [7:0] draw_byte;
  logic       list_commit;
  logic       frame_start;
  logic       busy;
  logic       list_dropped;
  logic [7:0] overrun_count;

  int checks = 0;
  int errors = 0;

  draw_list_scheduler_if bus ();

  draw_list_scheduler dut (
    .clock           (clock),
    .reset           (reset),
    .draw_start      (draw_start),
    .draw_byte_valid (draw_byte_valid),
    .draw_byte       (draw_byte),
    .list_commit     (list_commit),
    .frame_start     (frame_start),
    .out_if          (bus.master),
    .busy            (busy),
    .list_dropped    (list_dropped),
    .overrun_count   (overrun_count)
  );

  always #5 clock = ~clock;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    draw_byte_valid = 1'b1;
    draw_byte       = b;
    tick();
    draw_byte_valid = 1'b0;
  endtask

  task automatic send_record(input int id, input int x, input int y, input int fl, input bit with_frame);
    logic [15:0] xv;
    logic [15:0] yv;
    logic [7:0]  idv;
    logic [7:0]  flv;
    xv  = x[15:0];
    yv  = y[15:0];
    idv = id[7:0];
    flv = fl[7:0];
    draw_start = 1'b1;
    tick();
    draw_start = 1'b0;
    send_byte(idv);
    send_byte(xv[15:8]);
    send_byte(xv[7:0]);
    send_byte(yv[15:8]);
    send_byte(yv[7:0]);
    if (with_frame) begin
      list_commit = 1'b1;
      frame_start = 1'b1;
    end
    send_byte(flv);
    list_commit = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic pulse_commit();
    list_commit = 1'b1;
    tick();
    list_commit = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (bus.out_valid !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check_value({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
  endtask

  task automatic expect_entry(input string tag, input int id, input int x, input int y,
                              input int fl, input bit last);
    wait_valid(tag);
    check_value({tag, "_sprite"}, 32'(bus.out_sprite), id);
    check_value({tag, "_x"}, 32'(bus.out_x), x);
    check_value({tag, "_y"}, 32'(bus.out_y), y);
    check_value({tag, "_flags"}, 32'(bus.out_flags), fl);
    check_value({tag, "_last"}, 32'(bus.out_last), 32'(last));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    draw_start      = 1'b0;
    draw_byte_valid = 1'b0;
    draw_byte       = 8'd0;
    list_commit     = 1'b0;
    frame_start     = 1'b0;
    bus.out_ready   = 1'b0;
    repeat (3) tick();
    check_value("rst_valid", 32'(bus.out_valid), 32'd0);
    check_value("rst_busy", 32'(busy), 32'd0);
    check_value("rst_dropped", 32'(list_dropped), 32'd0);
    check_value("rst_overrun", 32'(overrun_count), 32'd0);
    check_value("rst_sprite", 32'(bus.out_sprite), 32'd0);
    check_value("rst_x", 32'(bus.out_x), 32'd0);
    reset = 1'b0;
    tick();

    // Partial record abandoned by a new draw_start, then two full records
    draw_start = 1'b1;
    tick();
    draw_start = 1'b0;
    send_byte(8'h0F);
    send_byte(8'h03);
    send_byte(8'hFF);
    send_record(3, 100, 50, 8'h01, 1'b0);
    send_record(5, 639, 479, 8'h80, 1'b0);
    pulse_commit();
    pulse_frame();
    check_value("lat_c1_valid", 32'(bus.out_valid), 32'd0);
    check_value("lat_c1_busy", 32'(busy), 32'd1);
    tick();
    check_value("lat_c2_valid", 32'(bus.out_valid), 32'd1);
    expect_entry("t1_e0", 3, 100, 50, 8'h01, 1'b0);
    expect_entry("t1_e1", 5, 639, 479, 8'h80, 1'b1);
    tick();
    check_value("t1_idle_busy", 32'(busy), 32'd0);
    check_value("t1_idle_valid", 32'(bus.out_valid), 32'd0);

    // Replay without commit; stall holds outputs
    pulse_frame();
    wait_valid("t2_w");
    for (int i = 0; i < 5; i++) begin
      tick();
      check_value("t2_stall_valid", 32'(bus.out_valid), 32'd1);
      check_value("t2_stall_sprite", 32'(bus.out_sprite), 32'd3);
      check_value("t2_stall_x", 32'(bus.out_x), 32'd100);
    end
    expect_entry("t2_e0", 3, 100, 50, 8'h01, 1'b0);
    expect_entry("t2_e1", 5, 639, 479, 8'h80, 1'b1);

    // Overrun during entry 2 of 4 restarts at entry 0
    for (int i = 1; i <= 4; i++) send_record(i, i * 100, i * 10, i, 1'b0);
    pulse_commit();
    pulse_frame();
    expect_entry("t3_e0", 1, 100, 10, 1, 1'b0);
    expect_entry("t3_e1", 2, 200, 20, 2, 1'b0);
    wait_valid("t3_e2");
    check_value("t3_e2_sprite", 32'(bus.out_sprite), 32'd3);
    pulse_frame();
    check_value("t3_abort_valid", 32'(bus.out_valid), 32'd0);
    check_value("t3_overrun", 32'(overrun_count), 32'd1);
    for (int i = 1; i <= 4; i++) expect_entry("t3_re", i, i * 100, i * 10, i, i == 4);

    // Full back list drops the 65th record
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_value("t4_rst_overrun", 32'(overrun_count), 32'd0);
    for (int i = 0; i < 65; i++) begin
      send_record(i % 16, i * 7, i, (i ^ 90) & 255, 1'b0);
      if (i == 63) check_value("t4_dropped_at64", 32'(list_dropped), 32'd0);
    end
    check_value("t4_dropped_at65", 32'(list_dropped), 32'd1);
    pulse_commit();
    check_value("t4_dropped_cleared", 32'(list_dropped), 32'd0);
    pulse_frame();
    for (int k = 0; k < 64; k++) expect_entry("t4_e", k % 16, k * 7, k, (k ^ 90) & 255, k == 63);
    tick();
    check_value("t4_done_busy", 32'(busy), 32'd0);

    // 6th byte, commit and frame_start together
    send_record(7, 1, 2, 8'h33, 1'b1);
    check_value("t5_c1_valid", 32'(bus.out_valid), 32'd0);
    tick();
    check_value("t5_c2_valid", 32'(bus.out_valid), 32'd1);
    expect_entry("t5_e0", 7, 1, 2, 8'h33, 1'b1);
    check_value("t5_overrun", 32'(overrun_count), 32'd0);

    // Reset in ISSUE, then an empty-list frame
    pulse_frame();
    wait_valid("t6_w0");
    pulse_frame();
    check_value("t6_overrun", 32'(overrun_count), 32'd1);
    wait_valid("t6_w1");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_value("t6_rst_valid", 32'(bus.out_valid), 32'd0);
    check_value("t6_rst_busy", 32'(busy), 32'd0);
    check_value("t6_rst_overrun", 32'(overrun_count), 32'd0);
    check_value("t6_rst_sprite", 32'(bus.out_sprite), 32'd0);
    pulse_frame();
    check_value("t6_empty_busy0", 32'(busy), 32'd0);
    tick();
    tick();
    check_value("t6_empty_valid", 32'(bus.out_valid), 32'd0);
    check_value("t6_empty_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
